// File: rtl/udp_rx_payload_extractor.sv
// UDP receive payload extractor.
// Parses Ethernet/IPv4/UDP headers from the MAC's 8-bit receive stream,
// keeps frames addressed to LOCAL_PORT, and packs their payload big-endian
// into a 32-bit first-word-fall-through stream. Each accepted frame reserves
// its full word count up front, so it is always delivered whole.
module udp_rx_payload_extractor #(
  parameter logic [15:0] LOCAL_PORT = 16'h1234,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic        clk_udp,
  input  logic        reset_udp,
  input  logic [7:0]  rx_axis_tdata,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [31:0] udpdata_tdata_out,
  output logic        udpdata_tvalid_out,
  output logic [3:0]  udpdata_tkeep_out,
  output logic        udpdata_tfirst_out,
  output logic        udpdata_tlast_out,
  output logic [15:0] udpdata_length_out,
  input  logic        udpdata_tready_in,
  output logic [15:0] drop_count_out,
  output logic        overflow_out,
  output logic        err_frame_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_WORDS = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_TAIL,
    S_DROP
  } state_t;

  state_t state;

  // Cleared by reset: a reset can land mid-frame, so the parser ignores
  // everything up to and including the next tlast before trusting offsets.
  logic        in_sync;
  logic [10:0] byte_cnt;
  logic        hdr_ok;
  logic [15:0] udp_len;
  logic [15:0] pay_len;
  logic [15:0] pay_idx;
  logic [31:0] acc;
  logic [1:0]  nb;
  logic        first_pend;
  logic        trunc_pend;

  // Word staged for the FIFO write one cycle after its final byte
  logic        w_vld;
  logic [31:0] w_data;
  logic [3:0]  w_keep;
  logic        w_first;
  logic        w_last;
  logic [15:0] w_len;

  // FIFO storage and bookkeeping
  logic [53:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic [53:0]   rd_word;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_nonempty;

  // Combinational datapath / decision signals
  logic        at_end;
  logic [31:0] word_new;
  logic [3:0]  keep_new;
  logic [15:0] pay_bytes;
  logic [16:0] need_words;
  logic [AW:0] free_words;
  logic        hdr_pass;
  logic        hdr_accept;
  logic        drop_evt;
  logic        ovf_evt;
  logic        err_evt;

  // Payload packing, header decision and per-byte event detection
  always_comb begin
    at_end     = (pay_idx + 16'd1) == pay_len;
    pay_bytes  = udp_len - 16'd8;
    need_words = (17'(pay_bytes) + 17'd3) >> 2;
    free_words = DEPTH_WORDS - fifo_count;
    hdr_pass   = hdr_ok && (udp_len >= 16'd8);
    word_new   = acc;
    keep_new   = 4'b1111;
    case (nb)
      2'd0: begin word_new = {rx_axis_tdata, 24'h000000};  keep_new = 4'b1000; end
      2'd1: begin word_new[23:16] = rx_axis_tdata;        keep_new = 4'b1100; end
      2'd2: begin word_new[15:8]  = rx_axis_tdata;        keep_new = 4'b1110; end
      default: begin word_new[7:0] = rx_axis_tdata;       keep_new = 4'b1111; end
    endcase

    hdr_accept = 1'b0;
    drop_evt   = 1'b0;
    ovf_evt    = 1'b0;
    err_evt    = 1'b0;
    if (rx_axis_tvalid && in_sync) begin
      case (state)
        S_IDLE: drop_evt = rx_axis_tlast;
        S_HDR: begin
          if (rx_axis_tlast) begin
            drop_evt = 1'b1;
          end else if (byte_cnt == 11'd41 && udp_len != 16'd8) begin
            if (!hdr_pass) begin
              drop_evt = 1'b1;
            end else if (need_words > 17'(free_words)) begin
              drop_evt = 1'b1;
              ovf_evt  = 1'b1;
            end else begin
              hdr_accept = 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_axis_tlast) begin
            drop_evt = !at_end;
            err_evt  = rx_axis_tuser;
          end
        end
        S_TAIL: err_evt = rx_axis_tlast && rx_axis_tuser;
        default: ;
      endcase
    end
  end

  // Receive parser FSM with registered staging word and pulse outputs
  always_ff @(posedge clk_udp or posedge reset_udp) begin
    if (reset_udp) begin
      state         <= S_IDLE;
      in_sync       <= 1'b0;
      byte_cnt      <= '0;
      hdr_ok        <= 1'b0;
      udp_len       <= '0;
      pay_len       <= '0;
      pay_idx       <= '0;
      acc           <= '0;
      nb            <= '0;
      first_pend    <= 1'b0;
      trunc_pend    <= 1'b0;
      w_vld         <= 1'b0;
      w_data        <= '0;
      w_keep        <= '0;
      w_first       <= 1'b0;
      w_last        <= 1'b0;
      w_len         <= '0;
      overflow_out  <= 1'b0;
      err_frame_out <= 1'b0;
    end else begin
      w_vld         <= 1'b0;
      overflow_out  <= ovf_evt;
      err_frame_out <= err_evt;

      // Closing empty word after a truncation that landed on a word boundary
      if (trunc_pend) begin
        w_vld      <= 1'b1;
        w_data     <= '0;
        w_keep     <= 4'b0000;
        w_first    <= 1'b0;
        w_last     <= 1'b1;
        w_len      <= pay_len;
        trunc_pend <= 1'b0;
      end

      if (rx_axis_tvalid) begin
        if (rx_axis_tlast)
          byte_cnt <= '0;
        else if (byte_cnt != '1)
          byte_cnt <= byte_cnt + 11'd1;

        if (!in_sync) begin
          if (rx_axis_tlast)
            in_sync <= 1'b1;
        end else begin
          case (state)
            S_IDLE: begin
              hdr_ok <= 1'b1;
              if (!rx_axis_tlast)
                state <= S_HDR;
            end

            S_HDR: begin
              case (byte_cnt)
                11'd12: if (rx_axis_tdata != 8'h08)            hdr_ok <= 1'b0;
                11'd13: if (rx_axis_tdata != 8'h00)            hdr_ok <= 1'b0;
                11'd14: if (rx_axis_tdata != 8'h45)            hdr_ok <= 1'b0;
                11'd23: if (rx_axis_tdata != 8'h11)            hdr_ok <= 1'b0;
                11'd36: if (rx_axis_tdata != LOCAL_PORT[15:8]) hdr_ok <= 1'b0;
                11'd37: if (rx_axis_tdata != LOCAL_PORT[7:0])  hdr_ok <= 1'b0;
                11'd38: udp_len[15:8] <= rx_axis_tdata;
                11'd39: udp_len[7:0]  <= rx_axis_tdata;
                default: ;
              endcase
              if (rx_axis_tlast) begin
                state <= S_IDLE;
              end else if (byte_cnt == 11'd41) begin
                if (hdr_accept) begin
                  state      <= S_PAYLOAD;
                  pay_len    <= pay_bytes;
                  pay_idx    <= '0;
                  nb         <= '0;
                  acc        <= '0;
                  first_pend <= 1'b1;
                end else begin
                  state <= S_DROP;
                end
              end
            end

            S_PAYLOAD: begin
              pay_idx <= pay_idx + 16'd1;
              nb      <= nb + 2'd1;
              acc     <= word_new;
              if (nb == 2'd3 || at_end || rx_axis_tlast) begin
                w_vld      <= 1'b1;
                w_data     <= word_new;
                w_keep     <= keep_new;
                w_first    <= first_pend;
                w_last     <= at_end || (rx_axis_tlast && nb != 2'd3);
                w_len      <= pay_len;
                first_pend <= 1'b0;
              end
              if (rx_axis_tlast) begin
                state <= S_IDLE;
                // A full word completed by the final byte still needs a
                // separate closing word to terminate the truncated frame.
                if (!at_end && nb == 2'd3)
                  trunc_pend <= 1'b1;
              end else if (at_end) begin
                state <= S_TAIL;
              end
            end

            S_TAIL, S_DROP: begin
              if (rx_axis_tlast)
                state <= S_IDLE;
            end

            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Saturating dropped-frame counter
  always_ff @(posedge clk_udp or posedge reset_udp) begin
    if (reset_udp)
      drop_count_out <= '0;
    else if (drop_evt && drop_count_out != 16'hFFFF)
      drop_count_out <= drop_count_out + 16'd1;
  end

  assign fifo_nonempty = fifo_count != '0;
  assign fifo_push     = w_vld;
  assign fifo_pop      = fifo_nonempty && udpdata_tready_in;
  assign rd_word       = fifo_mem[rd_ptr];

  // FIFO storage write port
  always_ff @(posedge clk_udp) begin
    if (fifo_push)
      fifo_mem[wr_ptr] <= {w_data, w_keep, w_first, w_last, w_len};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_udp or posedge reset_udp) begin
    if (reset_udp) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!fifo_push && fifo_pop)
        fifo_count <= fifo_count - 1'b1;
    end
  end

  // First-word-fall-through outputs, forced to zero while empty
  always_comb begin
    udpdata_tvalid_out = fifo_nonempty;
    udpdata_tdata_out  = '0;
    udpdata_tkeep_out  = '0;
    udpdata_tfirst_out = 1'b0;
    udpdata_tlast_out  = 1'b0;
    udpdata_length_out = '0;
    if (fifo_nonempty) begin
      udpdata_tdata_out  = rd_word[53:22];
      udpdata_tkeep_out  = rd_word[21:18];
      udpdata_tfirst_out = rd_word[17];
      udpdata_tlast_out  = rd_word[16];
      udpdata_length_out = rd_word[15:0];
    end
  end

endmodule

// File: doc/udp_rx_payload_extractor.md
Name: udp_rx_payload_extractor

Overview:
- Sits directly upstream of the UDP-to-SRIO bridge, in the clk_udp domain.
- Consumes the tri-mode MAC's 8-bit receive AXI-Stream and parses the Ethernet/IPv4/UDP headers.
- Filters for frames addressed to the local UDP port.
- Packs the payload into the 32-bit udpdata stream (tdata/tvalid/tkeep/tfirst/tlast/length/tready), reserving buffer space per frame so each accepted frame is delivered whole.

Parameters:
- LOCAL_PORT, 16'h1234, UDP destination port accepted; all others dropped.
- FIFO_DEPTH, 512, output buffer depth in 32-bit words; power of two, ≥ 368.

Ports:
- clk_udp  input  1  clock, 125 MHz MAC receive clock domain
- reset_udp  input  1  reset, asynchronous, active-high
- rx_axis_tdata  input  8  MAC receive byte
- rx_axis_tvalid  input  1  byte valid; no backpressure exists toward the MAC
- rx_axis_tlast  input  1  last byte of frame
- rx_axis_tuser  input  1  qualified by tlast; 1 = bad frame (FCS or length error)
- udpdata_tdata_out  output  32  payload word; first byte in [31:24]
- udpdata_tvalid_out  output  1  word valid
- udpdata_tkeep_out  output  4  byte enables, MSB-first
- udpdata_tfirst_out  output  1  first word of frame
- udpdata_tlast_out  output  1  last word of frame
- udpdata_length_out  output  16  payload bytes (UDP length − 8); constant for all words of a frame
- udpdata_tready_in  input  1  downstream ready
- drop_count_out  output  16  frames dropped; saturates at 16'hFFFF
- overflow_out  output  1  one-cycle pulse when a frame is dropped for lack of buffer space
- err_frame_out  output  1  one-cycle pulse when a frame ends with tuser=1 after payload was committed

Behaviour:
- Reset (asynchronous): all outputs 0; FIFO empty; state IDLE; byte counter 0; drop_count 0.
- Reset mid-frame: the remainder of that frame is ignored. The parser resynchronises on the byte after the next rx_axis_tlast.
- Byte counter: 11 bits; advances on each rx_axis_tvalid; clears after tlast.
- State machine:
  - IDLE → HDR on the first valid byte.
  - HDR captures fixed offsets and checks each one:
    - bytes 12–13 = 16'h0800;
    - byte 14 = 8'h45 (IPv4, no options);
    - byte 23 = 8'h11 (UDP);
    - bytes 36–37 = LOCAL_PORT;
    - bytes 38–39 = UDP length L, with L ≥ 8.
  - Decision is taken at byte 41, with P = L − 8 and W = ceil(P/4):
    - P = 0: go to DROP, uncounted.
    - Any check fails: go to DROP and increment drop_count.
    - Free FIFO words < W: go to DROP, increment drop_count, pulse overflow_out.
    - Otherwise go to PAYLOAD. Reserving W words guarantees no FIFO overflow mid-frame.
  - tlast seen in HDR: return to IDLE and increment drop_count (runt frame).
  - PAYLOAD: bytes from offset 42 are packed big-endian into a word accumulator.
    - A word is pushed on its 4th byte or on payload byte P.
    - tkeep for the last word: 1 byte = 1000, 2 = 1100, 3 = 1110, 4 = 1111.
    - tfirst is set on the first pushed word; tlast on the word holding byte P.
    - Bytes after byte P (Ethernet padding, FCS) are ignored until tlast; then go to IDLE.
  - Truncation: rx tlast arrives before byte P.
    - A partial word pending is pushed with tlast = 1.
    - No partial word pending: a word with tkeep = 0000 and tlast = 1 is pushed.
    - drop_count increments in both cases. The downstream framing stays closed.
  - tuser = 1 with tlast:
    - in HDR: counts as a drop;
    - in or after PAYLOAD: the data is already committed, so it is forwarded unchanged and err_frame_out pulses.
  - DROP: waits for tlast, then goes to IDLE.
- FIFO:
  - Entry fields: data, keep, first, last, length (54 bits).
  - First-word-fall-through: udpdata_tvalid_out = !empty.
  - Pop on tvalid & tready.
  - Outputs stay stable while tvalid & !tready.
  - Simultaneous push and pop in one cycle is supported; occupancy is unchanged.
- Latency: a word is written to the FIFO 1 cycle after its final byte. It appears on the output the following cycle when the FIFO was empty.
- Free-space check: uses current occupancy plus any words not yet popped from frames already committed. Pops during the decision cycle are ignored (conservative).

Test Plan:
- Good frame, port LOCAL_PORT, L = 18, payload 00..09, tready = 1 →
  - 3 words: 00010203/1111, 04050607/1111, 0809xxxx/1100;
  - tfirst on word 0, tlast on word 2, length = 10 on all words;
  - drop_count = 0.
- Dest port 16'h1235, then ethertype 16'h0806, then L = 6 → no output words; drop_count = 3.
- tready = 0, three 1024-byte-payload frames (256 words each) →
  - frames 1–2 buffered; frame 3 dropped with an overflow_out pulse, drop_count = 1;
  - after tready = 1: 512 words out in order, with tfirst/tlast at words 0, 255, 256, 511.
- L = 108 (P = 100), frame ends after 20 payload bytes →
  - 5 full words, then a 0000-keep tlast word;
  - drop_count = 1.
- Good 8-byte payload frame ending with tuser = 1 → 2 words delivered, err_frame_out pulses once.
- Assert reset_udp mid-payload →
  - tvalid drops to 0 immediately;
  - the next good 4-byte frame outputs exactly one word, with tfirst = tlast = 1 and keep = 1111.
